// File: rtl/delta_ctrl_pkg.sv
// Shared types and constants for the background-subtraction sequencer.
package delta_ctrl_pkg;

    typedef enum logic [1:0] {
        S_NOBG  = 2'd0,
        S_LEARN = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam int unsigned IMG_W_DEF = 320;
    localparam int unsigned IMG_H_DEF = 240;
    localparam int unsigned FRAME_PIX = IMG_W_DEF * IMG_H_DEF;

    // Cycles from the read strobe to the delta_frame output register.
    localparam int unsigned DELTA_LAT = 2;

    typedef struct packed {
        logic valid;
        logic last;
    } strobe_t;

endpackage

// File: rtl/frame_addr_cnt.sv
// Per-frame pixel counter: restarts on frame_start, refuses pixels past the frame size.
module frame_addr_cnt
    import delta_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_N = FRAME_PIX,
    parameter int unsigned CNT_W   = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             enable,
    input  logic             pix_valid,
    output logic [CNT_W-1:0] cnt_c,
    output logic             accept_c,
    output logic             overflow_c,
    output logic             at_end_c
);

    logic [CNT_W-1:0] pcnt;

    // A restart in the same cycle makes the coincident pixel index 0.
    always_comb begin
        cnt_c      = restart ? '0 : pcnt;
        accept_c   = pix_valid && enable && (cnt_c < CNT_W'(FRAME_N));
        overflow_c = pix_valid && enable && !(cnt_c < CNT_W'(FRAME_N));
        at_end_c   = (pcnt == CNT_W'(FRAME_N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (restart || accept_c) begin
            pcnt <= cnt_c + CNT_W'(accept_c);
        end
    end

endmodule

// File: rtl/delta_frame_ctrl.sv
// Background learn/compare sequencer: drives the background buffer port and
// aligns valid/last strobes to the delta_frame output register.
module delta_frame_ctrl
    import delta_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    input  logic              bg_capture_req,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] bg_addr,
    output logic              bg_we,
    output logic              bg_re,
    output logic [7:0]        bg_wdata,
    input  logic [7:0]        bg_rdata,
    output logic [7:0]        gray_o,
    output logic [7:0]        gray_bg,
    output logic              delta_valid,
    output logic              delta_last,
    output logic              bg_ready,
    output logic [15:0]       frame_cnt,
    output logic              err_short,
    output logic              err_long
);

    localparam int unsigned FRAME_N = IMG_W * IMG_H;
    localparam int unsigned CNT_W   = ADDR_W + 1;

    state_t                      state;
    state_t                      state_next;
    logic                        in_frame;
    logic                        capture_pending;
    logic                        cap_clr;
    logic                        short_set;
    logic                        frame_inc;
    logic [CNT_W-1:0]            cnt_c;
    logic                        accept_c;
    logic                        overflow_c;
    logic                        at_end_c;
    strobe_t [DELTA_LAT-1:0]     pipe;
    strobe_t                     stage_in;

    frame_addr_cnt #(
        .FRAME_N (FRAME_N),
        .CNT_W   (CNT_W)
    ) u_cnt (
        .clk        (clk_in),
        .rst_n      (reset_n),
        .restart    (frame_start),
        .enable     (in_frame || frame_start),
        .pix_valid  (pix_valid),
        .cnt_c      (cnt_c),
        .accept_c   (accept_c),
        .overflow_c (overflow_c),
        .at_end_c   (at_end_c)
    );

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) state <= S_NOBG;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        cap_clr    = 1'b0;
        short_set  = 1'b0;
        frame_inc  = 1'b0;
        case (state)
            S_NOBG: begin
                if (frame_start) state_next = S_LEARN;
            end
            S_LEARN: begin
                if (frame_start) begin
                    if (at_end_c) state_next = S_RUN;
                    else          short_set  = 1'b1;
                end
            end
            S_RUN: begin
                if (frame_start) begin
                    if (capture_pending || bg_capture_req) begin
                        state_next = S_LEARN;
                        cap_clr    = 1'b1;
                    end
                    if (at_end_c) frame_inc = 1'b1;
                    else          short_set = 1'b1;
                end
            end
            default: state_next = S_NOBG;
        endcase
    end

    // A pixel coincident with frame_start belongs to the frame being entered.
    always_comb begin
        bg_we    = accept_c && (state_next == S_LEARN);
        bg_re    = accept_c && (state_next == S_RUN);
        bg_addr  = ADDR_W'(cnt_c);
        bg_wdata = bg_we ? pix_data : 8'd0;
        gray_bg  = bg_rdata;
        bg_ready = (state == S_RUN);
        stage_in.valid = bg_re;
        stage_in.last  = bg_re && (cnt_c == CNT_W'(FRAME_N - 1));
        delta_valid = pipe[DELTA_LAT-1].valid;
        delta_last  = pipe[DELTA_LAT-1].last;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            in_frame        <= 1'b0;
            capture_pending <= 1'b0;
            gray_o          <= 8'd0;
            pipe            <= '0;
            frame_cnt       <= 16'd0;
            err_short       <= 1'b0;
            err_long        <= 1'b0;
        end else begin
            if (frame_start) in_frame <= 1'b1;
            if (cap_clr)                                  capture_pending <= 1'b0;
            else if (bg_capture_req && state != S_NOBG)   capture_pending <= 1'b1;
            if (accept_c) gray_o <= pix_data;
            pipe <= {pipe[DELTA_LAT-2:0], stage_in};
            if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
            if (short_set)       err_short <= 1'b1;
            else if (err_clr)    err_short <= 1'b0;
            if (overflow_c)      err_long  <= 1'b1;
            else if (err_clr)    err_long  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_delta_frame_ctrl.sv
// Directed bench for delta_frame_ctrl with a 4x2 frame and a behavioural background buffer.
module tb_delta_frame_ctrl;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        bg_capture_req;
    logic        err_clr;
    logic [2:0]  bg_addr;
    logic        bg_we;
    logic        bg_re;
    logic [7:0]  bg_wdata;
    logic [7:0]  bg_rdata = 8'd0;
    logic [7:0]  gray_o;
    logic [7:0]  gray_bg;
    logic        delta_valid;
    logic        delta_last;
    logic        bg_ready;
    logic [15:0] frame_cnt;
    logic        err_short;
    logic        err_long;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [8];

    always #5 clk_in = ~clk_in;

    delta_frame_ctrl #(
        .IMG_W  (4),
        .IMG_H  (2),
        .ADDR_W (3)
    ) dut (
        .clk_in         (clk_in),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .bg_capture_req (bg_capture_req),
        .err_clr        (err_clr),
        .bg_addr        (bg_addr),
        .bg_we          (bg_we),
        .bg_re          (bg_re),
        .bg_wdata       (bg_wdata),
        .bg_rdata       (bg_rdata),
        .gray_o         (gray_o),
        .gray_bg        (gray_bg),
        .delta_valid    (delta_valid),
        .delta_last     (delta_last),
        .bg_ready       (bg_ready),
        .frame_cnt      (frame_cnt),
        .err_short      (err_short),
        .err_long       (err_long)
    );

    // Background buffer with one-cycle synchronous read.
    always @(posedge clk_in) begin
        if (bg_we) mem[bg_addr] <= bg_wdata;
        if (bg_re) bg_rdata <= mem[bg_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic pv, input logic [7:0] pd,
                         input logic cr, input logic ec);
        @(negedge clk_in);
        frame_start    = fs;
        pix_valid      = pv;
        pix_data       = pd;
        bg_capture_req = cr;
        err_clr        = ec;
        #1;
    endtask

    initial begin
        frame_start = 0; pix_valid = 0; pix_data = 0;
        bg_capture_req = 0; err_clr = 0; reset_n = 0;
        repeat (2) @(negedge clk_in);
        #1;
        chk("rst_ready", bg_ready, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_eshort", err_short, 0);
        chk("rst_elong", err_long, 0);
        chk("rst_dvalid", delta_valid, 0);
        chk("rst_dlast", delta_last, 0);
        chk("rst_grayo", gray_o, 0);
        chk("rst_we", bg_we, 0);
        chk("rst_re", bg_re, 0);
        chk("rst_addr", bg_addr, 0);
        chk("rst_wdata", bg_wdata, 0);

        @(negedge clk_in);
        reset_n = 1;

        // Pixels before the first frame_start are ignored.
        drive(0, 1, 8'd99, 0, 0);
        chk("pre_we", bg_we, 0);
        chk("pre_re", bg_re, 0);

        // Learn frame 10..17.
        for (int k = 0; k < 8; k++) begin
            drive(k == 0, 1, 8'(10 + k), 0, 0);
            chk($sformatf("learn%0d_we", k), bg_we, 1);
            chk($sformatf("learn%0d_addr", k), bg_addr, k);
            chk($sformatf("learn%0d_wdata", k), bg_wdata, 10 + k);
            chk($sformatf("learn%0d_re", k), bg_re, 0);
            chk($sformatf("learn%0d_ready", k), bg_ready, 0);
        end

        // Compare frame, all pixels 20.
        for (int k = 0; k < 8; k++) begin
            drive(k == 0, 1, 8'd20, 0, 0);
            chk($sformatf("run%0d_re", k), bg_re, 1);
            chk($sformatf("run%0d_we", k), bg_we, 0);
            chk($sformatf("run%0d_addr", k), bg_addr, k);
            chk($sformatf("run%0d_ready", k), bg_ready, (k >= 1) ? 1 : 0);
            if (k >= 1) begin
                chk($sformatf("run%0d_graybg", k), gray_bg, 10 + k - 1);
                chk($sformatf("run%0d_grayo", k), gray_o, 20);
            end
            if (k >= 2) begin
                chk($sformatf("run%0d_dv", k), delta_valid, 1);
                chk($sformatf("run%0d_dl", k), delta_last, 0);
            end
        end

        // Short frame of 5 pixels; tail strobes of the compare frame drain here.
        for (int k = 0; k < 5; k++) begin
            drive(k == 0, 1, 8'(30 + k), 0, 0);
            chk($sformatf("short%0d_addr", k), bg_addr, k);
            chk($sformatf("short%0d_dv", k), delta_valid, 1);
            chk($sformatf("short%0d_dl", k), delta_last, (k == 1) ? 1 : 0);
        end
        chk("short_fcnt", frame_cnt, 1);
        chk("short_eshort_pre", err_short, 0);

        // Ten-pixel frame: err_short from the previous frame, err_clr, overflow.
        for (int k = 0; k < 10; k++) begin
            drive(k == 0, 1, 8'(40 + k), 0, k == 2);
            chk($sformatf("long%0d_addr_re", k), bg_re, (k < 8) ? 1 : 0);
            if (k < 8) chk($sformatf("long%0d_addr", k), bg_addr, k);
            chk($sformatf("long%0d_dv", k), delta_valid, 1);
            chk($sformatf("long%0d_dl", k), delta_last, (k == 9) ? 1 : 0);
            if (k == 1) begin
                chk("long_eshort_set", err_short, 1);
                chk("long_fcnt_hold", frame_cnt, 1);
            end
            if (k == 3) chk("long_eshort_clr", err_short, 0);
            if (k == 9) chk("long_elong_set", err_long, 1);
        end
        drive(0, 0, 8'd0, 0, 0);
        chk("long_drop_dv", delta_valid, 0);
        chk("long_elong_sticky", err_long, 1);

        // Compare frame with a capture request mid-frame.
        for (int k = 0; k < 8; k++) begin
            drive(k == 0, 1, 8'(50 + k), k == 3, 0);
            chk($sformatf("cap%0d_re", k), bg_re, 1);
            chk($sformatf("cap%0d_we", k), bg_we, 0);
            chk($sformatf("cap%0d_ready", k), bg_ready, 1);
            chk($sformatf("cap%0d_dv", k), delta_valid, (k >= 2) ? 1 : 0);
            if (k >= 1) chk($sformatf("cap%0d_graybg", k), gray_bg, 10 + k - 1);
            if (k >= 1) chk($sformatf("cap%0d_grayo", k), gray_o, 50 + k - 1);
            if (k == 1) chk("cap_fcnt", frame_cnt, 2);
        end

        // Relearn frame.
        for (int k = 0; k < 8; k++) begin
            drive(k == 0, 1, 8'(60 + k), 0, 0);
            chk($sformatf("relearn%0d_we", k), bg_we, 1);
            chk($sformatf("relearn%0d_re", k), bg_re, 0);
            chk($sformatf("relearn%0d_addr", k), bg_addr, k);
            chk($sformatf("relearn%0d_ready", k), bg_ready, (k == 0) ? 1 : 0);
            if (k < 3) chk($sformatf("relearn%0d_dv", k), delta_valid, (k < 2) ? 1 : 0);
            if (k < 2) chk($sformatf("relearn%0d_dl", k), delta_last, (k == 1) ? 1 : 0);
            if (k == 1) chk("relearn_fcnt", frame_cnt, 3);
        end

        // Back to compare, then an asynchronous reset with pixels in flight.
        drive(1, 1, 8'd70, 0, 0);
        chk("r7_0_re", bg_re, 1);
        chk("r7_0_ready", bg_ready, 0);
        drive(0, 1, 8'd71, 0, 0);
        chk("r7_1_ready", bg_ready, 1);
        drive(0, 1, 8'd72, 0, 0);
        chk("r7_2_dv", delta_valid, 1);
        @(negedge clk_in);
        pix_data = 8'd73;
        #1 reset_n = 0;
        #1;
        chk("arst_dv", delta_valid, 0);
        chk("arst_ready", bg_ready, 0);
        chk("arst_fcnt", frame_cnt, 0);
        chk("arst_elong", err_long, 0);
        chk("arst_grayo", gray_o, 0);
        chk("arst_re", bg_re, 0);
        chk("arst_we", bg_we, 0);
        @(negedge clk_in);
        reset_n = 1;
        drive(0, 1, 8'd80, 0, 0);
        chk("post_we", bg_we, 0);
        chk("post_re", bg_re, 0);
        drive(1, 1, 8'd81, 0, 0);
        chk("post_fs_we", bg_we, 1);
        chk("post_fs_addr", bg_addr, 0);
        chk("post_fs_wdata", bg_wdata, 81);
        chk("post_fs_ready", bg_ready, 0);
        drive(0, 0, 8'd0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
